// File: rtl/larpix_rx_pkg.sv
// Shared types, packet field offsets and field extractors for the LArPix receive path.
package larpix_rx_pkg;

    localparam int unsigned DECLARE_LSB = 0;
    localparam int unsigned DECLARE_W   = 2;
    localparam int unsigned CHIP_ID_LSB = 2;
    localparam int unsigned ADDR_LSB    = 10;
    localparam int unsigned DATA_LSB    = 18;
    localparam int unsigned FIELD_W     = 8;
    localparam int unsigned HDR_W       = 26;
    localparam int unsigned NUM_DECLARE = 4;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        DATA   = 2'd0,
        TEST   = 2'd1,
        CFG_WR = 2'd2,
        CFG_RD = 2'd3
    } pkt_declare_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_t;

    function automatic pkt_declare_t get_declare(input logic [HDR_W-1:0] hdr);
        return pkt_declare_t'(hdr[DECLARE_LSB +: DECLARE_W]);
    endfunction

    function automatic logic [FIELD_W-1:0] get_chip_id(input logic [HDR_W-1:0] hdr);
        return hdr[CHIP_ID_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_addr(input logic [HDR_W-1:0] hdr);
        return hdr[ADDR_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_data(input logic [HDR_W-1:0] hdr);
        return hdr[DATA_LSB +: FIELD_W];
    endfunction

    // Saturating increment shared by all statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/larpix_pkt_fifo.sv
// Synchronous FIFO with registered empty/half/full flags; head is presented without fall-through.
module larpix_pkt_fifo #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             half,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    // A full FIFO refuses writes even if a read frees a slot on the same edge.
    always_comb begin
        push      = wr_en && !full;
        pop       = rd_en && !empty;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            half   <= 1'b0;
            full   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            half  <= (count_nxt >= CW'(DEPTH / 2));
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/larpix_rx_aggregator.sv
// Round-robin merge of LArPix uart_rx lanes into one tagged packet FIFO,
// with per-type statistics and a config-read match/timeout engine.
module larpix_rx_aggregator
    import larpix_rx_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RD_TIMEOUT = 4096,
    parameter bit          DROP_BAD   = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CH-1:0]                         ch_valid,
    input  logic [NUM_CH*(WIDTH-1)-1:0]               ch_data,
    input  logic [NUM_CH-1:0]                         ch_perr,
    output logic [NUM_CH-1:0]                         ch_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [WIDTH-2:0]                          out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_channel,
    output logic                                      out_perr,
    output logic                                      fifo_half,
    output logic                                      fifo_full,
    input  logic                                      rd_req,
    input  logic [7:0]                                rd_chip_id,
    input  logic [7:0]                                rd_addr,
    output logic                                      rd_busy,
    output logic                                      rd_done,
    output logic [7:0]                                rd_data,
    output logic                                      rd_timeout,
    output logic [4*16-1:0]                           pkt_count,
    output logic [15:0]                               perr_count
);

    localparam int unsigned PKT_W = WIDTH - 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned ENT_W = CH_W + 1 + PKT_W;
    localparam int unsigned TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    logic [CH_W-1:0]    rr;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_any;
    int unsigned        idx;
    logic [PKT_W-1:0]   acc_data;
    logic               acc_perr;
    logic [HDR_W-1:0]   acc_hdr;
    logic               push;
    logic               rd_match;
    logic [ENT_W-1:0]   head;
    logic               fifo_empty;

    rd_state_t          rd_state;
    logic [TMR_W-1:0]   timer;
    logic [7:0]         rd_chip_q;
    logic [7:0]         rd_addr_q;

    // First valid lane at or after rr; nothing is granted while full or in reset.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        ch_ready  = '0;
        if (!reset && !fifo_full) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = (32'(rr) + k) % NUM_CH;
                if (!grant_any && ch_valid[CH_W'(idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = CH_W'(idx);
                end
            end
        end
        if (grant_any) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        acc_data = ch_data[32'(grant_idx) * PKT_W +: PKT_W];
        acc_perr = ch_perr[grant_idx];
        acc_hdr  = acc_data[HDR_W-1:0];
        push     = grant_any && !(acc_perr && DROP_BAD);
        rd_match = (rd_state == RD_WAIT) && grant_any && !acc_perr
                   && (get_declare(acc_hdr) == CFG_RD)
                   && (get_chip_id(acc_hdr) == rd_chip_q)
                   && (get_addr(acc_hdr) == rd_addr_q);
    end

    larpix_pkt_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({grant_idx, acc_perr, acc_data}),
        .rd_en   (out_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .half    (fifo_half),
        .full    (fifo_full)
    );

    assign out_valid   = !fifo_empty;
    assign out_channel = head[ENT_W-1 -: CH_W];
    assign out_perr    = head[PKT_W];
    assign out_data    = head[PKT_W-1:0];

    // Round-robin pointer and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr         <= '0;
            pkt_count  <= '0;
            perr_count <= '0;
        end else if (grant_any) begin
            rr <= (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
            if (acc_perr) begin
                perr_count <= sat_inc(perr_count);
            end else begin
                for (int unsigned d = 0; d < NUM_DECLARE; d++) begin
                    if (DECLARE_W'(d) == acc_hdr[DECLARE_LSB +: DECLARE_W]) begin
                        pkt_count[d*CNT_W +: CNT_W] <= sat_inc(pkt_count[d*CNT_W +: CNT_W]);
                    end
                end
            end
        end
    end

    // Config-read engine: a match on the timeout cycle still counts as a match.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state   <= RD_IDLE;
            timer      <= '0;
            rd_chip_q  <= '0;
            rd_addr_q  <= '0;
            rd_busy    <= 1'b0;
            rd_done    <= 1'b0;
            rd_data    <= '0;
            rd_timeout <= 1'b0;
        end else begin
            rd_done    <= 1'b0;
            rd_timeout <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (rd_req) begin
                        rd_chip_q <= rd_chip_id;
                        rd_addr_q <= rd_addr;
                        timer     <= '0;
                        rd_busy   <= 1'b1;
                        rd_state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_match) begin
                        rd_done  <= 1'b1;
                        rd_data  <= get_data(acc_hdr);
                        rd_busy  <= 1'b0;
                        rd_state <= RD_IDLE;
                    end else if (timer == TMR_W'(RD_TIMEOUT - 1)) begin
                        rd_timeout <= 1'b1;
                        rd_busy    <= 1'b0;
                        rd_state   <= RD_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: doc/larpix_rx_aggregator.md
# larpix_rx_aggregator

Synthesizable multi-lane receive front end for the FPGA-side LArPix master. It accepts deserialized 63-bit packets from `NUM_CH` `uart_rx` lanes and arbitrates them round-robin into one tagged packet FIFO. It also counts packets by type, drops parity-bad packets, and closes configuration-read transactions with a match-or-timeout engine. It sits between the per-lane `uart_rx` instances and the host readout and register-access logic.

## Interface
- `NUM_CH`, 4: number of receive lanes, 1..16.
- `WIDTH`, 64: UART word width; packet width is `WIDTH-1`.
- `FIFO_DEPTH`, 16: output FIFO entries, power of two, ≥2.
- `RD_TIMEOUT`, 4096: cycles to wait for a config-read reply.
- `DROP_BAD`, 1: 1 discards parity-bad packets; 0 forwards them with `out_perr=1`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous reset, active-high.
- `ch_valid` in NUM_CH: lane holds a packet.
- `ch_data` in NUM_CH*(WIDTH-1): lane packets, lane i at `[i*(WIDTH-1) +: WIDTH-1]`.
- `ch_perr` in NUM_CH: lane parity error, qualified by `ch_valid`.
- `ch_ready` out NUM_CH: one-hot grant; packet consumed on `ch_valid & ch_ready`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: host pops the head.
- `out_data` out WIDTH-1: head packet.
- `out_channel` out $clog2(NUM_CH) (min 1): lane tag of the head packet.
- `out_perr` out 1: head packet had a parity error; only when DROP_BAD=0.
- `fifo_half` out 1: occupancy ≥ FIFO_DEPTH/2.
- `fifo_full` out 1: occupancy = FIFO_DEPTH.
- `rd_req` in 1: start a config-read wait.
- `rd_chip_id` in 8: chip expected to reply, sampled on `rd_req`.
- `rd_addr` in 8: register expected in the reply, sampled on `rd_req`.
- `rd_busy` out 1: read wait in progress.
- `rd_done` out 1: one-cycle pulse, matching reply seen.
- `rd_data` out 8: reply data, held until the next `rd_done`.
- `rd_timeout` out 1: one-cycle pulse, no reply within RD_TIMEOUT.
- `pkt_count` out 4*16: saturating counts by packet_declare 0..3, declare d at `[d*16 +: 16]`.
- `perr_count` out 16: saturating parity-error count.

## Operation
- Packet fields:
  - declare `[1:0]`: 0 data, 1 test, 2 cfg write, 3 cfg read.
  - chip_id `[9:2]`.
  - regmap addr `[17:10]`.
  - regmap data `[25:18]`.
- Arbiter:
  - Grants only while `!fifo_full`.
  - Picks the first valid lane at or after pointer `rr`.
  - `ch_ready` is combinational, at most one bit high.
  - After a grant to lane i, `rr` becomes (i+1) mod NUM_CH; `rr` is unchanged with no grant.
- On every accept:
  - Good packet: increments `pkt_count[declare]`.
  - Parity-bad packet: increments `perr_count` only.
  - Every accepted packet is written to the FIFO as {lane, perr, data}, except a parity-bad packet when DROP_BAD=1.
- Read engine FSM, states IDLE → WAIT:
  - IDLE: `rd_req=1` latches chip/addr, clears the timer, enters WAIT and raises `rd_busy`.
  - WAIT: `rd_req` is ignored.
  - WAIT, match: an accepted good declare-3 packet with equal chip_id and addr pulses `rd_done`, loads `rd_data`, returns to IDLE. The packet is still forwarded to the FIFO.
  - WAIT, timeout: the timer reaching RD_TIMEOUT-1 with no match pulses `rd_timeout` and returns to IDLE.
  - A match on the same cycle as the timeout: match wins.
- All counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - `ch_ready`, `out_valid`, `out_perr`, `fifo_half`, `fifo_full` = 0.
  - `rd_busy`, `rd_done`, `rd_timeout` = 0.
  - `rd_data`, `out_data`, `out_channel`, all counts = 0.
  - `rr` = 0, FSM in IDLE.
- Reset mid-operation flushes the FIFO, aborts the read wait with no pulse, and zeroes counts.
- Accept at edge t: the packet becomes visible on `out_valid`/`out_data` after edge t if the FIFO was empty. Latency is 1 cycle, with no fall-through.
- Pop: on `out_valid & out_ready`. With pop and push on the same cycle, occupancy is unchanged.
- `fifo_full` blocks a push even when a pop happens in the same cycle.
- `rd_done` rises the cycle after the matching accept.
- `rd_timeout` rises RD_TIMEOUT cycles after the `rd_req` edge.
- `pkt_count`/`perr_count` update the cycle after accept.
- Flags are registered and reflect occupancy after the current edge.

## Structure
- Package `larpix_rx_pkg`:
  - `pkt_declare_t` enum (DATA, TEST, CFG_WR, CFG_RD).
  - Field offset localparams.
  - `rd_state_t`.
  - Extractor functions `get_chip_id`, `get_addr`, `get_data`.
- Sub-module `larpix_pkt_fifo`: synchronous FIFO parametrised by width and depth, with full/half/empty flags. The arbiter, counters and read FSM stay in the top.

## Test plan
- Single lane, NUM_CH=4: lane 2 sends 63'h0000_0000_0000_1234 with declare 0 → `out_data` equals it one cycle later, `out_channel`=2, `pkt_count[0]`=1.
- All four lanes valid continuously → grant order 0,1,2,3,0; each lane receives exactly 4 of 16 grants.
- `out_ready`=0 with 16 packets pushed → `fifo_full`=1 and `ch_ready`=0. Then one pop plus one valid lane → no push that cycle, push on the next.
- `ch_perr`=1 on lane 1, DROP_BAD=1 → `perr_count`=1, `out_valid` stays 0, `pkt_count` unchanged. With DROP_BAD=0 → packet forwarded with `out_perr`=1.
- `rd_req` for chip 16, addr 5:
  - A reply with chip 16, addr 5, data 8'hA5 at cycle 20 → `rd_done` at 21, `rd_data`=8'hA5.
  - A reply with chip 16, addr 6 → no `rd_done`; `rd_timeout` 4096 cycles after `rd_req`.
- Assert `reset` during WAIT with 5 packets queued → next cycle `out_valid`=0, `rd_busy`=0, counts 0, and no `rd_done`/`rd_timeout` pulse.
